// File: rtl/soc_ctrl_boot_seq.sv
// Boot sequencer: programs and polls the PLLs, loads boot addresses and hart IDs,
// then releases clock/reset domains in order. `SOC_BOOT_SEQ_GPR_STAMP_EN adds a GPR_0 stamp step.
module soc_ctrl_boot_seq #(
  parameter int          ADDR_WIDTH        = 8,
  parameter int          DATA_WIDTH        = 32,
  parameter logic [3:0]  PLL_REF_DIV       = 4'd1,
  parameter logic [11:0] PLL_FB_DIV        = 12'd40,
  parameter logic        CORE_LINK_MUX_SEL = 1'b1,
  parameter int          LOCK_TIMEOUT      = 1024
) (
  input  logic                    clk_i,
  input  logic                    arst_ni,
  input  logic                    start_i,
  input  logic [DATA_WIDTH-1:0]   core_0_boot_addr_i,
  input  logic [DATA_WIDTH-1:0]   core_1_boot_addr_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [4:0]              err_step_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_waddr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb_o,
  input  logic [1:0]              mem_wresp_i,
  output logic                    mem_re_o,
  output logic [ADDR_WIDTH-1:0]   mem_raddr_o,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  input  logic [1:0]              mem_rresp_i
);

  localparam int CNT_W = $clog2(LOCK_TIMEOUT + 1);

  localparam logic [ADDR_WIDTH-1:0] A_PLL_SYS_LINK  = ADDR_WIDTH'(8'h00);
  localparam logic [ADDR_WIDTH-1:0] A_PLL_CORE_0    = ADDR_WIDTH'(8'h04);
  localparam logic [ADDR_WIDTH-1:0] A_PLL_CORE_1    = ADDR_WIDTH'(8'h08);
  localparam logic [ADDR_WIDTH-1:0] A_BOOT_CORE_0   = ADDR_WIDTH'(8'h0C);
  localparam logic [ADDR_WIDTH-1:0] A_BOOT_CORE_1   = ADDR_WIDTH'(8'h10);
  localparam logic [ADDR_WIDTH-1:0] A_HART_CORE_0   = ADDR_WIDTH'(8'h14);
  localparam logic [ADDR_WIDTH-1:0] A_HART_CORE_1   = ADDR_WIDTH'(8'h18);
  localparam logic [ADDR_WIDTH-1:0] A_CR_SYS_LINK   = ADDR_WIDTH'(8'h1C);
  localparam logic [ADDR_WIDTH-1:0] A_CR_PERIPH     = ADDR_WIDTH'(8'h20);
  localparam logic [ADDR_WIDTH-1:0] A_CR_CORE_LINK  = ADDR_WIDTH'(8'h24);
  localparam logic [ADDR_WIDTH-1:0] A_CR_CORE_0     = ADDR_WIDTH'(8'h28);
  localparam logic [ADDR_WIDTH-1:0] A_CR_CORE_1     = ADDR_WIDTH'(8'h2C);
`ifdef SOC_BOOT_SEQ_GPR_STAMP_EN
  localparam logic [ADDR_WIDTH-1:0] A_GPR_0         = ADDR_WIDTH'(8'h30);
  localparam logic [4:0]            LAST_STEP       = 5'd20;
`else
  localparam logic [4:0]            LAST_STEP       = 5'd19;
`endif

  typedef enum logic [2:0] {IDLE, WRITE, POLL, DONE, ERROR} state_e;

  state_e           state_q, state_d;
  logic [4:0]       step_q, step_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [4:0]       err_step_q, err_step_d;

  function automatic logic [ADDR_WIDTH-1:0] step_addr(input logic [4:0] step);
    case (step)
      5'd0, 5'd3:   step_addr = A_PLL_SYS_LINK;
      5'd1, 5'd4:   step_addr = A_PLL_CORE_0;
      5'd2, 5'd5:   step_addr = A_PLL_CORE_1;
      5'd6:         step_addr = A_BOOT_CORE_0;
      5'd7:         step_addr = A_BOOT_CORE_1;
      5'd8:         step_addr = A_HART_CORE_0;
      5'd9:         step_addr = A_HART_CORE_1;
      5'd10, 5'd11: step_addr = A_CR_SYS_LINK;
      5'd12, 5'd13: step_addr = A_CR_PERIPH;
      5'd14, 5'd15: step_addr = A_CR_CORE_LINK;
      5'd16, 5'd17: step_addr = A_CR_CORE_0;
      5'd18, 5'd19: step_addr = A_CR_CORE_1;
`ifdef SOC_BOOT_SEQ_GPR_STAMP_EN
      5'd20:        step_addr = A_GPR_0;
`endif
      default:      step_addr = '0;
    endcase
  endfunction

  // Clock/reset steps come in pairs: even = clock on with reset held, odd = reset released.
  function automatic logic [DATA_WIDTH-1:0] step_wdata(input logic [4:0]            step,
                                                        input logic [DATA_WIDTH-1:0] boot0,
                                                        input logic [DATA_WIDTH-1:0] boot1);
    case (step)
      5'd0, 5'd1, 5'd2: step_wdata = DATA_WIDTH'({16'b0, PLL_FB_DIV, PLL_REF_DIV});
      5'd6:             step_wdata = boot0;
      5'd7:             step_wdata = boot1;
      5'd8:             step_wdata = '0;
      5'd9:             step_wdata = DATA_WIDTH'(1);
      5'd14:            step_wdata = DATA_WIDTH'({CORE_LINK_MUX_SEL, 2'b10});
      5'd15:            step_wdata = DATA_WIDTH'({CORE_LINK_MUX_SEL, 2'b11});
      5'd10, 5'd12, 5'd16, 5'd18: step_wdata = DATA_WIDTH'(2);
      5'd11, 5'd13, 5'd17, 5'd19: step_wdata = DATA_WIDTH'(3);
`ifdef SOC_BOOT_SEQ_GPR_STAMP_EN
      5'd20:            step_wdata = DATA_WIDTH'(32'hB007_D0E5);
`endif
      default:          step_wdata = '0;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q    <= IDLE;
      step_q     <= '0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_step_q <= '0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      cnt_q      <= cnt_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_step_q <= err_step_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    cnt_d       = cnt_q;
    done_d      = done_q;
    error_d     = error_q;
    err_step_d  = err_step_q;
    mem_we_o    = 1'b0;
    mem_waddr_o = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    mem_re_o    = 1'b0;
    mem_raddr_o = '0;

    case (state_q)
      WRITE: begin
        mem_we_o    = 1'b1;
        mem_waddr_o = step_addr(step_q);
        mem_wdata_o = step_wdata(step_q, core_0_boot_addr_i, core_1_boot_addr_i);
        mem_wstrb_o = '1;
        if (mem_wresp_i != 2'b00) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_step_d = step_q;
        end else if (step_q == LAST_STEP) begin
          state_d = DONE;
          done_d  = 1'b1;
        end else begin
          step_d = step_q + 5'd1;
          if (step_q == 5'd2) state_d = POLL;
        end
      end
      POLL: begin
        mem_re_o    = 1'b1;
        mem_raddr_o = step_addr(step_q);
        if (mem_rresp_i != 2'b00) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_step_d = step_q;
        end else if (mem_rdata_i[16]) begin
          cnt_d  = '0;
          step_d = step_q + 5'd1;
          if (step_q == 5'd5) state_d = WRITE;
        end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
          state_d    = ERROR;
          error_d    = 1'b1;
          err_step_d = step_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        if (start_i) begin
          state_d    = WRITE;
          step_d     = '0;
          cnt_d      = '0;
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_step_d = '0;
        end
      end
    endcase
  end

  logic unused_rdata;
  assign unused_rdata = ^{mem_rdata_i};

  assign busy_o     = (state_q == WRITE) || (state_q == POLL);
  assign done_o     = done_q;
  assign error_o    = error_q;
  assign err_step_o = err_step_q;

endmodule

// File: doc/soc_ctrl_boot_seq.md
Name: soc_ctrl_boot_seq

Overview:
- Hardware boot sequencer that initiates transactions on the soc_ctrl memory register interface, on the initiator side.
- On a start pulse it programs the three PLLs, polls their lock bits, loads the core boot addresses and hart IDs, then brings up each clock/reset domain in a fixed order.
- It sits between the always-on power-on logic and the soc_ctrl register block, muxed with the bus-side initiator.
- Firmware never has to run on an unclocked core.

Parameters:
- ADDR_WIDTH, DHS_ADDRW: register address width.
- DATA_WIDTH, DHS_DATAW: register data width (32 in this design).
- PLL_REF_DIV, 4'd1: ref divider written to all PLLs (REF_DIV_BW bits).
- PLL_FB_DIV, 12'd40: feedback divider written to all PLLs (FB_DIV_BW bits).
- CORE_LINK_MUX_SEL, 1'b1: value written to core-link clk_mux_sel.
- LOCK_TIMEOUT, 1024: maximum poll cycles per PLL before error.

Ports:
- clk_i, in, 1: system clock.
- arst_ni, in, 1: asynchronous active-low reset.
- start_i, in, 1: start pulse.
- core_0_boot_addr_i, in, DATA_WIDTH: boot address for core 0.
- core_1_boot_addr_i, in, DATA_WIDTH: boot address for core 1.
- busy_o, out, 1: sequence in progress.
- done_o, out, 1: sequence completed OK (sticky).
- error_o, out, 1: sequence aborted (sticky).
- err_step_o, out, 5: step index at abort.
- mem_we_o, out, 1: write enable.
- mem_waddr_o, out, ADDR_WIDTH: write address.
- mem_wdata_o, out, DATA_WIDTH: write data.
- mem_wstrb_o, out, DATA_WIDTH/8: write strobes.
- mem_wresp_i, in, 2: write response (00 OKAY, 10 SLVERR).
- mem_re_o, out, 1: read enable.
- mem_raddr_o, out, ADDR_WIDTH: read address.
- mem_rdata_i, in, DATA_WIDTH: read data.
- mem_rresp_i, in, 2: read response.

Behaviour:
- One clock (clk_i); reset arst_ni is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE; step_q=0; timeout counter 0.
- Interface timing: responder answers combinationally in the same cycle. Each access occupies exactly one cycle. Response is sampled at the rising edge ending that cycle. mem_wstrb_o is all ones whenever mem_we_o=1.
- mem_we_o and mem_re_o are never high together. Address/data outputs are 0 when the matching enable is low.
- FSM states: IDLE, WRITE, POLL, DONE, ERROR.
- IDLE/DONE/ERROR + start_i=1: go to WRITE; step_q=0; clear done_o, error_o, err_step_o. start_i is ignored in WRITE and POLL.
- busy_o = (state is WRITE or POLL).
- Step table (step_q -> access):
  - 0-2: write PLL_CONFIG SYS_LINK, CORE_0, CORE_1 = {16'b0, PLL_FB_DIV, PLL_REF_DIV}.
  - 3-5: POLL reads of the same three registers, in the same order.
  - 6-7: write BOOT_ADDR_CORE_0/1 = core_0/1_boot_addr_i, sampled in the write cycle.
  - 8-9: write HART_ID_CORE_0 = 0, HART_ID_CORE_1 = 1.
  - 10,11: CLK_RST_SYS_LINK = 0x2 then 0x3 (clock on with reset held, then reset released).
  - 12,13: CLK_RST_PERIPH_LINK = 0x2, 0x3.
  - 14,15: CLK_RST_CORE_LINK = {CORE_LINK_MUX_SEL,1,0}, then {CORE_LINK_MUX_SEL,1,1}.
  - 16,17: CLK_RST_CORE_0 = 0x2, 0x3.
  - 18,19: CLK_RST_CORE_1 = 0x2, 0x3.
- Step advance:
  - WRITE with wresp=00: step_q+1.
  - Step 2 done: go to POLL.
  - Last step done: go to DONE, done_o=1.
- POLL:
  - rresp=00 and rdata[16]=1 (lock bit, above FB/REF fields): advance and reset the counter. After step 5, go to WRITE.
  - rdata[16]=0: re-read next cycle, counter+1.
  - Counter reaching LOCK_TIMEOUT-1 without lock: go to ERROR.
- Any wresp/rresp != 00: go to ERROR; error_o=1; err_step_o=step_q. No further accesses.
- Minimum latency: start sampled at edge 0 -> first write in cycle 1; done_o=1 after edge 20 (20 access cycles, all PLLs locked on first read).
- Reset mid-sequence: return to IDLE immediately, enables drop asynchronously. Already-written registers are not rolled back.

Optional Feature:
- Macro SOC_BOOT_SEQ_GPR_STAMP_EN.
- Defined: extra step 20 writes GPR_0 = 32'hB007_D0E5 before DONE. Nominal done edge becomes 21. An SLVERR here is reported with err_step_o=20.
- Undefined: sequence ends after step 19; GPR_0 is never touched.

Test Plan:
- Nominal run: all PLLs locked, all OKAY, start pulse -> exactly 20 accesses in table order; done_o=1 after edge 20; CLK_RST_CORE_1 reads 0x3; CORE_LINK reads 0x7.
- Slow lock: core_0 PLL locks after 37 reads -> 37 reads of PLL_CONFIG_CORE_0 before step 6; done_o after edge 56; error_o=0.
- Lock timeout: core_1 PLL never locks, LOCK_TIMEOUT=16 -> 16 reads at step 5; error_o=1; err_step_o=5; no CLK_RST writes issued.
- SLVERR: responder returns wresp=10 on step 12 -> error_o=1; err_step_o=12; mem_we_o low afterwards; a new start_i restarts at step 0 and clears error_o.
- Reset at step 8 -> all outputs 0 in the same cycle; start after reset release reruns the full sequence; start_i pulsed while busy is ignored (access count stays 20).
- With SOC_BOOT_SEQ_GPR_STAMP_EN -> 21st access writes GPR_0=0xB007D0E5; done_o after edge 21.
